// File: rtl/reset_sequencer.sv
// Central reset producer: synchronizes board reset release, waits for PLL lock,
// then releases NUM_RST active-low synchronous resets in a fixed staged order.
module reset_sequencer #(
  parameter int NUM_RST     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STEP_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pll_lock,
  input  logic               sw_rst_req,
  output logic               sw_rst_ack,
  output logic [NUM_RST-1:0] rstn_out,
  output logic               rst_done
);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [NUM_RST-1:0] FIRST     = NUM_RST'(1);
  localparam logic [NUM_RST-1:0] ALL_ONES  = '1;
  // Thermometer pattern with every output released except the last one.
  localparam logic [NUM_RST-1:0] PENULT    = ALL_ONES >> 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rst_sync;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_RST-1:0] rstn_q, rstn_d;
  logic               done_q, done_d;
  logic               ack_q, ack_d;

  // Assertion is asynchronous; release is retimed through SYNC_STAGES flops.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign rst_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      rstn_q  <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rstn_q  <= rstn_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
    end
  end

  // Outputs only ever change as a thermometer: bits rise one at a time, and all
  // fall together on re-entry to HOLD.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    rstn_d  = rstn_q;
    done_d  = done_q;
    ack_d   = 1'b0;

    if (rst_sync) begin
      state_d = HOLD;
      cnt_d   = '0;
      rstn_d  = '0;
      done_d  = 1'b0;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (!pll_lock) begin
            cnt_d = '0;
          end else if (cnt_q >= HOLD_LAST) begin
            rstn_d = FIRST;
            cnt_d  = '0;
            if (NUM_RST == 1) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        RELEASE: begin
          if (!pll_lock) begin
            state_d = HOLD;
            cnt_d   = '0;
            rstn_d  = '0;
            done_d  = 1'b0;
          end else if (cnt_q >= STEP_LAST) begin
            rstn_d = (rstn_q << 1) | FIRST;
            cnt_d  = '0;
            if (rstn_q == PENULT) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        DONE: begin
          // Lock loss outranks a warm reset request and suppresses the ack.
          if (!pll_lock || sw_rst_req) begin
            state_d = HOLD;
            cnt_d   = '0;
            rstn_d  = '0;
            done_d  = 1'b0;
            ack_d   = pll_lock;
          end
        end

        default: begin
          state_d = HOLD;
          cnt_d   = '0;
          rstn_d  = '0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  assign rstn_out   = rstn_q;
  assign rst_done   = done_q;
  assign sw_rst_ack = ack_q;

endmodule
